// File: rtl/vga_timing_gen.sv
// Video timing generator: H/V counters, a fetch stage one cycle behind the counters,
// and a LEAD-deep display stage carrying position, enable and sync levels.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int LEAD     = 2,
    parameter int CW       = 11
) (
    input  logic          VGACLK,
    input  logic          RST_IN,
    input  logic          CE,
    output logic [CW-1:0] FETCH_X,
    output logic [CW-1:0] FETCH_Y,
    output logic          FETCH_EN,
    output logic [CW-1:0] POS_X,
    output logic [CW-1:0] POS_Y,
    output logic          DISPLAY_EN,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic          LINE_START,
    output logic          FRAME_START
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] HC_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] VC_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] r_hc;
    logic [CW-1:0] r_vc;

    // Stage 0 is the fetch stage, stage LEAD is the display stage.
    logic [CW-1:0] r_x  [0:LEAD];
    logic [CW-1:0] r_y  [0:LEAD];
    logic          r_en [0:LEAD];
    logic          r_hs [0:LEAD];
    logic          r_vs [0:LEAD];

    logic          w_f_en;
    logic          w_f_hs;
    logic          w_f_vs;
    logic [CW-1:0] w_ld_x;
    logic [CW-1:0] w_ld_y;
    logic          w_ld_v;

    always_comb begin
        w_f_en = (r_hc < H_ACT) && (r_vc < V_ACT);
        w_f_hs = ((r_hc >= HS_START) && (r_hc < HS_END)) ? H_POL : ~H_POL;
        w_f_vs = ((r_vc >= VS_START) && (r_vc < VS_END)) ? V_POL : ~V_POL;
    end

    always_ff @(posedge VGACLK) begin
        if (!RST_IN) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (CE) begin
            if (r_hc == HC_LAST) begin
                r_hc <= '0;
                r_vc <= (r_vc == VC_LAST) ? '0 : r_vc + 1'b1;
            end else begin
                r_hc <= r_hc + 1'b1;
            end
        end
    end

    // Sync levels are stored already polarity-adjusted so HSYNC/VSYNC come straight off flops.
    always_ff @(posedge VGACLK) begin
        if (!RST_IN) begin
            for (int k = 0; k <= LEAD; k++) begin
                r_x[k]  <= '0;
                r_y[k]  <= '0;
                r_en[k] <= 1'b0;
                r_hs[k] <= ~H_POL;
                r_vs[k] <= ~V_POL;
            end
        end else if (CE) begin
            r_x[0]  <= r_hc;
            r_y[0]  <= r_vc;
            r_en[0] <= w_f_en;
            r_hs[0] <= w_f_hs;
            r_vs[0] <= w_f_vs;
            for (int k = 1; k <= LEAD; k++) begin
                r_x[k]  <= r_x[k-1];
                r_y[k]  <= r_y[k-1];
                r_en[k] <= r_en[k-1];
                r_hs[k] <= r_hs[k-1];
                r_vs[k] <= r_vs[k-1];
            end
        end
    end

    // The valid bits keep flushed reset zeros from looking like a (0,0) load.
    generate
        if (LEAD == 0) begin : g_nolead
            assign w_ld_x = r_hc;
            assign w_ld_y = r_vc;
            assign w_ld_v = 1'b1;
        end else begin : g_lead
            logic r_v [0:LEAD-1];
            always_ff @(posedge VGACLK) begin
                if (!RST_IN) begin
                    for (int k = 0; k < LEAD; k++) r_v[k] <= 1'b0;
                end else if (CE) begin
                    r_v[0] <= 1'b1;
                    for (int k = 1; k < LEAD; k++) r_v[k] <= r_v[k-1];
                end
            end
            assign w_ld_x = r_x[LEAD-1];
            assign w_ld_y = r_y[LEAD-1];
            assign w_ld_v = r_v[LEAD-1];
        end
    endgenerate

    always_ff @(posedge VGACLK) begin
        if (!RST_IN) begin
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            LINE_START  <= CE && w_ld_v && (w_ld_x == '0);
            FRAME_START <= CE && w_ld_v && (w_ld_x == '0) && (w_ld_y == '0);
        end
    end

    assign FETCH_X    = r_x[0];
    assign FETCH_Y    = r_y[0];
    assign FETCH_EN   = r_en[0];
    assign POS_X      = r_x[LEAD];
    assign POS_Y      = r_y[LEAD];
    assign DISPLAY_EN = r_en[LEAD];
    assign HSYNC      = r_hs[LEAD];
    assign VSYNC      = r_vs[LEAD];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using tiny timing (H 8/1/2/1, V 4/1/1/1, H_POL=1),
// comparing a LEAD=2 and a LEAD=0 instance against an independent counter model.
module tb_vga_timing_gen;
    localparam int CW = 4;
    localparam int HA = 8, HF = 1, HS = 2, HB = 1;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam bit HP = 1'b1;
    localparam bit VP = 1'b0;
    localparam int TW = 2*CW + 3;
    localparam int OW = 4*CW + 6;

    typedef logic [TW-1:0] tup_t;

    logic VGACLK = 1'b0;
    logic RST_IN = 1'b0;
    logic CE = 1'b0;

    logic [CW-1:0] f2x, f2y, p2x, p2y, f0x, f0y, p0x, p0y;
    logic f2en, d2en, hs2, vs2, ls2, fs2;
    logic f0en, d0en, hs0, vs0, ls0, fs0;

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .H_POL(HP), .V_POL(VP), .LEAD(2), .CW(CW)) dut2 (
        .VGACLK(VGACLK), .RST_IN(RST_IN), .CE(CE),
        .FETCH_X(f2x), .FETCH_Y(f2y), .FETCH_EN(f2en),
        .POS_X(p2x), .POS_Y(p2y), .DISPLAY_EN(d2en),
        .HSYNC(hs2), .VSYNC(vs2), .LINE_START(ls2), .FRAME_START(fs2));

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .H_POL(HP), .V_POL(VP), .LEAD(0), .CW(CW)) dut0 (
        .VGACLK(VGACLK), .RST_IN(RST_IN), .CE(CE),
        .FETCH_X(f0x), .FETCH_Y(f0y), .FETCH_EN(f0en),
        .POS_X(p0x), .POS_Y(p0y), .DISPLAY_EN(d0en),
        .HSYNC(hs0), .VSYNC(vs0), .LINE_START(ls0), .FRAME_START(fs0));

    always #5 VGACLK = ~VGACLK;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   m_hc = 0;
    int   m_vc = 0;
    int   n_push = 0;
    tup_t q[$];
    bit   e_ls [2];
    bit   e_fs [2];

    function automatic tup_t mk(input int hc, input int vc);
        tup_t t;
        t[TW-1 -: CW]    = CW'(hc);
        t[TW-1-CW -: CW] = CW'(vc);
        t[2] = (hc < HA) && (vc < VA);
        t[1] = (hc >= HA + HF && hc < HA + HF + HS) ? HP : !HP;
        t[0] = (vc >= VA + VF && vc < VA + VF + VS) ? VP : !VP;
        return t;
    endfunction

    function automatic tup_t rst_t();
        tup_t t;
        t = '0;
        t[1] = !HP;
        t[0] = !VP;
        return t;
    endfunction

    function automatic tup_t disp_t(input int lead);
        if (n_push > lead) return q[q.size() - 1 - lead];
        return rst_t();
    endfunction

    function automatic logic [OW-1:0] exp_vec(input int lead, input int si);
        tup_t f;
        tup_t d;
        f = (n_push > 0) ? q[$] : rst_t();
        d = disp_t(lead);
        return {f[TW-1:2], d, e_ls[si], e_fs[si]};
    endfunction

    function automatic logic [OW-1:0] obs2();
        return {f2x, f2y, f2en, p2x, p2y, d2en, hs2, vs2, ls2, fs2};
    endfunction

    function automatic logic [OW-1:0] obs0();
        return {f0x, f0y, f0en, p0x, p0y, d0en, hs0, vs0, ls0, fs0};
    endfunction

    // Drives one clock edge and pushes the expected outcome into the scoreboard.
    task automatic tick(input bit ce, input bit rstn);
        tup_t d;
        int   lead;
        CE = ce;
        RST_IN = rstn;
        @(posedge VGACLK);
        cyc++;
        if (!rstn) begin
            m_hc = 0;
            m_vc = 0;
            n_push = 0;
            q.delete();
            for (int si = 0; si < 2; si++) begin e_ls[si] = 0; e_fs[si] = 0; end
        end else if (ce) begin
            q.push_back(mk(m_hc, m_vc));
            n_push++;
            if (m_hc == HT - 1) begin
                m_hc = 0;
                m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
            end else begin
                m_hc++;
            end
            while (q.size() > 3) void'(q.pop_front());
            for (int si = 0; si < 2; si++) begin
                lead = (si == 1) ? 2 : 0;
                e_ls[si] = 0;
                e_fs[si] = 0;
                if (n_push > lead) begin
                    d = q[q.size() - 1 - lead];
                    e_ls[si] = (d[TW-1 -: CW] == 0);
                    e_fs[si] = (d[TW-1 -: CW] == 0) && (d[TW-1-CW -: CW] == 0);
                end
            end
        end else begin
            for (int si = 0; si < 2; si++) begin e_ls[si] = 0; e_fs[si] = 0; end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [OW-1:0] rv;
        rv = {{(2*CW+1){1'b0}}, {(2*CW+1){1'b0}}, !HP, !VP, 2'b00};
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if (obs2() !== rv) begin
            errors++;
            $display("FAIL reset_lead2 got=%h exp=%h", obs2(), rv);
        end
        checks++;
        if (obs0() !== rv) begin
            errors++;
            $display("FAIL reset_lead0 got=%h exp=%h", obs0(), rv);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (obs2() !== exp_vec(2, 1) || obs0() !== exp_vec(0, 0)) begin
                errors++;
                $display("FAIL hold_after_reset cyc=%0d got2=%h exp2=%h got0=%h exp0=%h",
                         cyc, obs2(), exp_vec(2, 1), obs0(), exp_vec(0, 0));
            end
        end
    endtask

    task automatic test_first_frame();
        tick(1'b1, 1'b1);
        checks++;
        if (f2x !== 0 || f2y !== 0 || f2en !== 1'b1 || fs2 !== 1'b0 || fs0 !== 1'b1) begin
            errors++;
            $display("FAIL first_edge fetch=(%0d,%0d,%b) fs2=%b fs0=%b exp fetch=(0,0,1) fs2=0 fs0=1",
                     f2x, f2y, f2en, fs2, fs0);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (obs2() !== exp_vec(2, 1) || obs0() !== exp_vec(0, 0)) begin
                errors++;
                $display("FAIL first_frame cyc=%0d got2=%h exp2=%h got0=%h exp0=%h",
                         cyc, obs2(), exp_vec(2, 1), obs0(), exp_vec(0, 0));
            end
        end
        checks++;
        if (fs2 !== 1'b1 || p2x !== 0 || p2y !== 0 || d2en !== 1'b1) begin
            errors++;
            $display("FAIL lead2_first_display fs=%b pos=(%0d,%0d) en=%b exp fs=1 pos=(0,0) en=1",
                     fs2, p2x, p2y, d2en);
        end
    endtask

    task automatic test_free_run();
        int last_fs = -1, prev_fs = -1, n_de = 0, n_hs = 0;
        for (int i = 0; i < 2*HT*VT + 8; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (obs2() !== exp_vec(2, 1) || obs0() !== exp_vec(0, 0)) begin
                errors++;
                $display("FAIL free_run cyc=%0d got2=%h exp2=%h got0=%h exp0=%h",
                         cyc, obs2(), exp_vec(2, 1), obs0(), exp_vec(0, 0));
            end
            if (fs2) begin prev_fs = last_fs; last_fs = i; end
            if (i < HT*VT) begin
                n_de += int'(d2en);
                n_hs += int'(hs2);
            end
        end
        checks++;
        if (prev_fs < 0 || last_fs - prev_fs != HT*VT) begin
            errors++;
            $display("FAIL frame_period got=%0d exp=%0d", last_fs - prev_fs, HT*VT);
        end
        checks++;
        if (n_de != HA*VA) begin
            errors++;
            $display("FAIL display_en_count got=%0d exp=%0d", n_de, HA*VA);
        end
        checks++;
        if (n_hs != HS*VT) begin
            errors++;
            $display("FAIL hsync_active_count got=%0d exp=%0d", n_hs, HS*VT);
        end
    endtask

    task automatic test_ce_gap();
        int last_fs = -1, prev_fs = -1;
        logic prev_ls = 1'b0;
        for (int i = 0; i < 6*HT*VT + 24; i++) begin
            tick((i % 3) == 0, 1'b1);
            checks++;
            if (obs2() !== exp_vec(2, 1) || obs0() !== exp_vec(0, 0)) begin
                errors++;
                $display("FAIL ce_gap cyc=%0d got2=%h exp2=%h got0=%h exp0=%h",
                         cyc, obs2(), exp_vec(2, 1), obs0(), exp_vec(0, 0));
            end
            if (prev_ls && ls2) begin
                checks++;
                errors++;
                $display("FAIL strobe_width cyc=%0d got=2 cycles exp=1", cyc);
            end
            prev_ls = ls2;
            if (fs2) begin prev_fs = last_fs; last_fs = i; end
        end
        checks++;
        if (prev_fs < 0 || last_fs - prev_fs != 3*HT*VT) begin
            errors++;
            $display("FAIL ce_gap_period got=%0d exp=%0d", last_fs - prev_fs, 3*HT*VT);
        end
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        while (!(m_hc == 5 && m_vc == 2) && guard < 2*HT*VT) begin
            tick(1'b1, 1'b1);
            guard++;
        end
        checks++;
        if (guard >= 2*HT*VT) begin
            errors++;
            $display("FAIL mid_reset_reach got=timeout exp=(5,2)");
        end
        tick(1'b1, 1'b0);
        checks++;
        if (obs2() !== exp_vec(2, 1) || obs0() !== exp_vec(0, 0) || hs2 !== !HP || vs2 !== !VP) begin
            errors++;
            $display("FAIL mid_reset got2=%h exp2=%h got0=%h exp0=%h",
                     obs2(), exp_vec(2, 1), obs0(), exp_vec(0, 0));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < HT*VT + 5; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (obs2() !== exp_vec(2, 1) || obs0() !== exp_vec(0, 0)) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got2=%h exp2=%h got0=%h exp0=%h",
                         cyc, obs2(), exp_vec(2, 1), obs0(), exp_vec(0, 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_free_run();
        test_ce_gap();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
